multicycle_ctrl: RTL and testbench

Multicycle control FSM sitting directly upstream of the 32-bit ALU. Each instruction is sequenced over 3–5 cycles. Every cycle the block drives:
- the ALU's 3-bit `alu_control` and operand-select lines;
- register-file and memory strobes;
- PC/IR write enables.

Memory accesses use a req/ready handshake guarded by a watchdog. Illegal encodings and watchdog expiry park the FSM in a sticky FAULT state.

---
 rtl/multicycle_ctrl_if.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Purpose : Bundles the control FSM's datapath/memory-facing signals.
// Signals :
//   opcode, funct, zero, mem_ready         -> into the controller
//   mem_req, mem_write, iord, ir_write,
//   pc_write, pc_src, reg_write, reg_dst,
//   mem_to_reg, alu_src_a, alu_src_b,
//   alu_control, fault, state              <- from the controller
// Modports: master = controller, slave = datapath / memory side.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_control, fault, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               alu_control, fault, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Purpose : Multicycle control FSM in front of a 32-bit ALU datapath. Sequences
//           lw/sw/R-type/beq/addi/j over 3-5 cycles, with a req/ready memory
//           handshake guarded by a watchdog; illegal encodings or watchdog
//           expiry park the FSM in a sticky FAULT state (exit by reset only).
// Ports   :
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset; forces every output to 0 while low
//   bus    - multicycle_ctrl_if.master (decode inputs, control outputs)
// Params  :
//   MAX_WAIT - tolerated consecutive not-ready cycles per access (0 = off)
// Config  :
//   MULTICYCLE_CTRL_BNE_EN - when defined, opcode 000101 (bne) is legal.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    localparam int unsigned CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned WD_LIMIT = (MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_FAULT    = 4'd15
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_is_sw;      // lw/sw choice, captured in DECODE
`ifdef MULTICYCLE_CTRL_BNE_EN
    logic               r_is_bne;     // beq/bne choice, captured in DECODE
`endif

    logic               w_funct_ok;
    logic               w_wd_fire;

    logic               w_mem_req;
    logic               w_mem_write;
    logic               w_iord;
    logic               w_ir_write;
    logic               w_pc_write;
    logic [1:0]         w_pc_src;
    logic               w_reg_write;
    logic               w_reg_dst;
    logic               w_mem_to_reg;
    logic               w_alu_src_a;
    logic [1:0]         w_alu_src_b;
    logic [2:0]         w_alu_control;
    logic               w_fault;

    // Supported R-type function codes
    always_comb begin
        case (bus.funct)
            6'b100000, 6'b100010, 6'b100100,
            6'b100101, 6'b101010: w_funct_ok = 1'b1;
            default:              w_funct_ok = 1'b0;
        endcase
    end

    // Watchdog fires on the last tolerated not-ready cycle; ready wins
    assign w_wd_fire = (MAX_WAIT > 0) && w_mem_req && !bus.mem_ready &&
                       (r_wait_cnt == CNT_W'(WD_LIMIT));

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (bus.mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    6'b100011, 6'b101011: w_next_state = S_MEMADR;
                    6'b000000:            w_next_state = w_funct_ok ? S_EXECUTE : S_FAULT;
                    6'b000100:            w_next_state = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    6'b000101:            w_next_state = S_BRANCH;
`endif
                    6'b001000:            w_next_state = S_ADDIEXEC;
                    6'b000010:            w_next_state = S_JUMP;
                    default:              w_next_state = S_FAULT;
                endcase
            end
            S_MEMADR:   w_next_state = r_is_sw ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) w_next_state = S_FETCH;
            S_EXECUTE:  w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_ADDIEXEC: w_next_state = S_ADDIWB;
            S_ADDIWB:   w_next_state = S_FETCH;
            S_JUMP:     w_next_state = S_FETCH;
            S_FAULT:    w_next_state = S_FAULT;
            default:    w_next_state = S_FAULT;
        endcase
        if (w_wd_fire) begin
            w_next_state = S_FAULT;
        end
    end

    // State, watchdog counter and decode captures
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_is_sw    <= 1'b0;
`ifdef MULTICYCLE_CTRL_BNE_EN
            r_is_bne   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (bus.mem_ready || (w_next_state != r_state)) begin
                r_wait_cnt <= '0;
            end else if (w_mem_req) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (r_state == S_DECODE) begin
                r_is_sw  <= (bus.opcode == 6'b101011);
`ifdef MULTICYCLE_CTRL_BNE_EN
                r_is_bne <= (bus.opcode == 6'b000101);
`endif
            end
        end
    end

    // Per-state control decode (outputs follow the current state)
    always_comb begin
        w_mem_req     = 1'b0;
        w_mem_write   = 1'b0;
        w_iord        = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = 2'b00;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_alu_control = 3'b000;
        w_fault       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req     = 1'b1;
                w_alu_src_b   = 2'b01;
                w_alu_control = 3'b010;
                w_ir_write    = bus.mem_ready;
                w_pc_write    = bus.mem_ready;
            end
            S_DECODE: begin
                w_alu_src_b   = 2'b11;
                w_alu_control = 3'b010;
            end
            S_MEMADR, S_ADDIEXEC: begin
                w_alu_src_a   = 1'b1;
                w_alu_src_b   = 2'b10;
                w_alu_control = 3'b010;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
            end
            S_EXECUTE: begin
                w_alu_src_a = 1'b1;
                case (bus.funct)
                    6'b100010: w_alu_control = 3'b110;
                    6'b100100: w_alu_control = 3'b000;
                    6'b100101: w_alu_control = 3'b001;
                    6'b101010: w_alu_control = 3'b111;
                    default:   w_alu_control = 3'b010;
                endcase
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = 3'b110;
                w_pc_src      = 2'b01;
`ifdef MULTICYCLE_CTRL_BNE_EN
                w_pc_write    = r_is_bne ? !bus.zero : bus.zero;
`else
                w_pc_write    = bus.zero;
`endif
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_fault = 1'b0;
            end
        endcase
    end

    // Reset masks every output in the same cycle it is asserted
    assign bus.mem_req     = rst_n & w_mem_req;
    assign bus.mem_write   = rst_n & w_mem_write;
    assign bus.iord        = rst_n & w_iord;
    assign bus.ir_write    = rst_n & w_ir_write;
    assign bus.pc_write    = rst_n & w_pc_write;
    assign bus.pc_src      = rst_n ? w_pc_src      : 2'b00;
    assign bus.reg_write   = rst_n & w_reg_write;
    assign bus.reg_dst     = rst_n & w_reg_dst;
    assign bus.mem_to_reg  = rst_n & w_mem_to_reg;
    assign bus.alu_src_a   = rst_n & w_alu_src_a;
    assign bus.alu_src_b   = rst_n ? w_alu_src_b   : 2'b00;
    assign bus.alu_control = rst_n ? w_alu_control : 3'b000;
    assign bus.fault       = rst_n & w_fault;
    assign bus.state       = rst_n ? r_state       : 4'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Purpose : Self-checking bench for multicycle_ctrl. Each instruction is turned
//           into an expected per-cycle state trace from the instruction's
//           cycle budget and wait counts; per-state control values come from
//           a table of the documented state outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic clk;
    logic rst_n;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MAX_WAIT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Expected trace for the current instruction
    int q_st[$];
    bit q_rdy[$];

    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] dut_vec();
        return {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_src, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.fault};
    endfunction

    // Documented control outputs for each state
    function automatic logic [16:0] exp_out(input int st, input bit rdy, input bit z,
                                            input bit bne, input logic [5:0] fn);
        logic       mreq, mwr, iord, irw, pcw, rw, rd, m2r, asa, flt;
        logic [1:0] psrc, asb;
        logic [2:0] alu;
        {mreq, mwr, iord, irw, pcw, rw, rd, m2r, asa, flt} = '0;
        psrc = 2'b00; asb = 2'b00; alu = 3'b000;
        case (st)
            0:  begin mreq = 1; asb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'b11; alu = 3'b010; end
            2, 9: begin asa = 1; asb = 2'b10; alu = 3'b010; end
            3:  begin mreq = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mreq = 1; mwr = 1; iord = 1; end
            6:  begin
                    asa = 1;
                    case (fn)
                        6'b100010: alu = 3'b110;
                        6'b100100: alu = 3'b000;
                        6'b100101: alu = 3'b001;
                        6'b101010: alu = 3'b111;
                        default:   alu = 3'b010;
                    endcase
                end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; alu = 3'b110; psrc = 2'b01; pcw = bne ? !z : z; end
            10: begin rw = 1; end
            11: begin psrc = 2'b10; pcw = 1; end
            15: begin flt = 1; end
            default: begin flt = 0; end
        endcase
        return {mreq, mwr, iord, irw, pcw, psrc, rw, rd, m2r, asa, asb, alu, flt};
    endfunction

    // Drive one cycle just after the edge, check mid-cycle
    task automatic step(input int st, input bit rdy, input logic [5:0] op,
                        input logic [5:0] fn, input bit z, input bit bne);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        @(negedge clk);
        check("state", 32'(bus.state), 32'(st));
        check("ctrl", 32'(dut_vec()), 32'(exp_out(st, rdy, z, bne, fn)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            rst_n         = 1'b0;
            bus.mem_ready = 1'($urandom);
            bus.opcode    = 6'($urandom);
            bus.funct     = 6'($urandom);
            bus.zero      = 1'($urandom);
            @(negedge clk);
            check("rst_state", 32'(bus.state), 32'd0);
            check("rst_ctrl", 32'(dut_vec()), 32'd0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic push_plain(input int st);
        q_st.push_back(st);
        q_rdy.push_back(1'($urandom));
    endtask

    // Memory phase: w not-ready cycles then ready; 15 not-ready cycles is fatal
    task automatic push_wait(input int st, input int w, output bit faulted);
        faulted = 1'b0;
        for (int i = 0; i < w && i < 15; i++) begin
            q_st.push_back(st);
            q_rdy.push_back(1'b0);
        end
        if (w >= 15) begin
            push_plain(15);
            faulted = 1'b1;
        end else begin
            q_st.push_back(st);
            q_rdy.push_back(1'b1);
        end
    endtask

    // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 addi, 6 bne, 7 bad opcode, 8 bad funct
    task automatic run_instr(input int kind, input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input int zmode, input int cut);
        bit f;
        int n;
        int st;
        q_st.delete();
        q_rdy.delete();
        push_wait(0, wf, f);
        if (!f) begin
            push_plain(1);
            case (kind)
                0: begin push_plain(6); push_plain(7); end
                1: begin push_plain(2); push_wait(3, wm, f); if (!f) push_plain(4); end
                2: begin push_plain(2); push_wait(5, wm, f); end
                3: push_plain(8);
                4: push_plain(11);
                5: begin push_plain(9); push_plain(10); end
`ifdef MULTICYCLE_CTRL_BNE_EN
                6: push_plain(8);
`else
                6: push_plain(15);
`endif
                default: push_plain(15);
            endcase
        end
        if (q_st[q_st.size()-1] == 15) begin
            repeat (10) push_plain(15);
        end
        n = (cut >= 0 && cut < q_st.size()) ? cut : q_st.size();
        for (int i = 0; i < n; i++) begin
            st = q_st[i];
            step(st, q_rdy[i],
                 (st == 1 || st == 6) ? op : 6'($urandom),
                 (st == 1 || st == 6) ? fn : 6'($urandom),
                 (zmode == 2) ? 1'($urandom) : 1'(zmode),
                 kind == 6);
        end
        if (n < q_st.size() || q_st[q_st.size()-1] == 15) begin
            do_reset(1 + int'($urandom_range(1, 0)));
        end
    endtask

    function automatic bit is_legal_op(input logic [5:0] op);
        return op inside {6'b000000, 6'b000010, 6'b000100, 6'b000101,
                          6'b001000, 6'b100011, 6'b101011};
    endfunction

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(19, 0));
        if (r < 14) return r % 4;
        if (r < 17) return 14;
        return 15;
    endfunction

    initial begin
        int         kind;
        logic [5:0] op;
        logic [5:0] fn;

        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;

        do_reset(2);

        run_instr(0, 6'b000000, 6'b100000, 0, 0, 2, -1);   // R-type add
        run_instr(0, 6'b000000, 6'b100010, 0, 0, 2, -1);   // sub
        run_instr(0, 6'b000000, 6'b101010, 1, 0, 2, -1);   // slt, one fetch wait
        run_instr(1, 6'b100011, 6'b010101, 0, 3, 2, -1);   // lw, 3 wait cycles
        run_instr(2, 6'b101011, 6'b000000, 0, 0, 2, -1);   // sw
        run_instr(3, 6'b000100, 6'b000000, 0, 0, 1, -1);   // beq taken
        run_instr(3, 6'b000100, 6'b000000, 0, 0, 0, -1);   // beq not taken
        run_instr(4, 6'b000010, 6'b000000, 0, 0, 2, -1);   // j
        run_instr(5, 6'b001000, 6'b000000, 0, 0, 2, -1);   // addi
        run_instr(0, 6'b000000, 6'b100000, 14, 0, 2, -1);  // ready on 15th fetch cycle
        run_instr(0, 6'b000000, 6'b100000, 15, 0, 2, -1);  // fetch watchdog expiry
        run_instr(1, 6'b100011, 6'b000000, 0, 15, 2, -1);  // read watchdog expiry
        run_instr(7, 6'b111111, 6'b000000, 0, 0, 2, -1);   // illegal opcode, sticky
        run_instr(8, 6'b000000, 6'b111000, 0, 0, 2, -1);   // illegal funct
        run_instr(6, 6'b000101, 6'b000000, 0, 0, 1, -1);   // bne
        run_instr(6, 6'b000101, 6'b000000, 0, 0, 0, -1);
        run_instr(2, 6'b101011, 6'b000000, 0, 5, 2, 4);    // reset mid-MEMWRITE
        run_instr(0, 6'b000000, 6'b100101, 0, 0, 2, -1);   // clean restart after reset

        repeat (250) begin
            kind = int'($urandom_range(8, 0));
            fn   = 6'($urandom);
            case (kind)
                0: begin op = 6'b000000; fn = legal_fn[$urandom_range(4, 0)]; end
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                6: op = 6'b000101;
                7: begin
                       op = 6'($urandom);
                       while (is_legal_op(op)) op = 6'($urandom);
                   end
                default: begin
                       op = 6'b000000;
                       while (fn inside {6'b100000, 6'b100010, 6'b100100,
                                         6'b100101, 6'b101010}) fn = 6'($urandom);
                   end
            endcase
            run_instr(kind, op, fn, pick_wait(), pick_wait(), 2,
                      ($urandom_range(7, 0) == 0) ? int'($urandom_range(6, 0)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
